sprite_cmd_sequencer: RTL and testbench

- Upstream feeder for all sprite display components (Bowser, Mario, tiles, …) on the shared 32-bit command bus `cmd_out`.
- The CPU pushes sprite commands over Avalon-MM into a FIFO, then writes a commit.
- At the next vertical-blank entry the block replays the committed commands, stamping each with the back-buffer index. It then broadcasts a buffer-toggle command to every component ID, so all sprites swap ping/pong state atomically, tear-free.

---
 rtl/sprite_seq_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/sprite_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sprite_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_seq_pkg.sv
// Shared definitions for the sprite command sequencer: command field layout,
// register map, FSM state encoding and command-building helpers.
package sprite_seq_pkg;

  localparam int CMD_W      = 32;
  localparam int COMP_LSB   = 26;
  localparam int COMP_W     = 6;
  localparam int CHILD_LSB  = 21;
  localparam int CHILD_W    = 5;
  localparam int ACTION_LSB = 17;
  localparam int ACTION_W   = 4;
  localparam int TYPE_LSB   = 14;
  localparam int TYPE_W     = 3;
  localparam int BUF_BIT    = 13;
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 13;

  localparam logic [ACTION_W-1:0] ACTION_UPDATE = 4'h1;
  localparam logic [ACTION_W-1:0] ACTION_TOGGLE = 4'hF;

  localparam logic [1:0] ADDR_PUSH   = 2'd0;
  localparam logic [1:0] ADDR_COMMIT = 2'd1;
  localparam logic [1:0] ADDR_CLEAR  = 2'd2;
  localparam logic [1:0] ADDR_NONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    TOGGLE = 2'd2
  } seq_state_e;

  // Replace the buffer bit of a queued command with the back-buffer index.
  function automatic logic [CMD_W-1:0] stamp_cmd(input logic [CMD_W-1:0] word,
                                                 input logic back_idx);
    stamp_cmd          = word;
    stamp_cmd[BUF_BIT] = back_idx;
  endfunction

  function automatic logic [CMD_W-1:0] toggle_cmd(input logic [COMP_W-1:0] id,
                                                  input logic back_idx);
    toggle_cmd                              = '0;
    toggle_cmd[COMP_LSB +: COMP_W]          = id;
    toggle_cmd[ACTION_LSB +: ACTION_W]      = ACTION_TOGGLE;
    toggle_cmd[BUF_BIT]                     = back_idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push and pop in the same
// cycle are both honoured. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// Queues CPU sprite commands and replays a committed batch at vblank entry,
// then broadcasts a buffer toggle to every component. Optional irq: SPRITE_SEQ_IRQ_EN.
module sprite_cmd_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int MAX_ID     = 63,
  parameter int V_ACTIVE   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
`ifdef SPRITE_SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic [31:0] cmd_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e        state, state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  commit_cnt;
  logic [CNT_W-1:0]  drain_left, drain_left_next;
  logic [COMP_W-1:0] id_q, id_next;
  logic [31:0]       head;
  logic [31:0]       cmd_next;
  logic [31:0]       status;
  logic [9:0]        vcount_q;
  logic              full;
  logic              empty;
  logic              pop;
  logic              done;
  logic              trigger;
  logic              pending;
  logic              overflow;
  logic              back_idx;
  logic              push_req;
  logic              commit_req;
  logic              clear_req;

  always_comb begin
    push_req   = 1'b0;
    commit_req = 1'b0;
    clear_req  = 1'b0;
    if (chipselect && write) begin
      case (address)
        ADDR_PUSH:   push_req   = 1'b1;
        ADDR_COMMIT: commit_req = 1'b1;
        ADDR_CLEAR:  clear_req  = 1'b1;
        ADDR_NONE:   ;
        default:     ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (writedata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Rising edge into the first blanking line; holding vcount there cannot retrigger.
  assign trigger = (vcount == 10'(V_ACTIVE)) && (vcount_q != 10'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (reset) begin
      vcount_q   <= '0;
      overflow   <= 1'b0;
      pending    <= 1'b0;
      commit_cnt <= '0;
      back_idx   <= 1'b1;
    end else begin
      vcount_q <= vcount;
      if (push_req && full) overflow <= 1'b1;
      else if (clear_req)   overflow <= 1'b0;
      if (commit_req && !pending) begin
        pending    <= 1'b1;
        commit_cnt <= count;
      end else if (done) begin
        pending <= 1'b0;
      end
      if (done) back_idx <= ~back_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      drain_left <= '0;
      id_q       <= '0;
      cmd_out    <= '0;
    end else begin
      state      <= state_next;
      drain_left <= drain_left_next;
      id_q       <= id_next;
      cmd_out    <= cmd_next;
    end
  end

  // cmd_next is what cmd_out shows in the following cycle, so each branch
  // prepares the word that belongs to the next state's first cycle.
  always_comb begin
    state_next      = state;
    drain_left_next = drain_left;
    id_next         = id_q;
    cmd_next        = '0;
    pop             = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && pending) begin
          if (commit_cnt != '0) begin
            pop             = 1'b1;
            cmd_next        = stamp_cmd(head, back_idx);
            drain_left_next = commit_cnt - CNT_W'(1);
            state_next      = DRAIN;
          end else begin
            id_next    = COMP_W'(1);
            cmd_next   = toggle_cmd(COMP_W'(1), back_idx);
            state_next = TOGGLE;
          end
        end
      end
      DRAIN: begin
        if (drain_left != '0) begin
          pop             = 1'b1;
          cmd_next        = stamp_cmd(head, back_idx);
          drain_left_next = drain_left - CNT_W'(1);
        end else begin
          id_next    = COMP_W'(1);
          cmd_next   = toggle_cmd(COMP_W'(1), back_idx);
          state_next = TOGGLE;
        end
      end
      TOGGLE: begin
        if (id_q == COMP_W'(MAX_ID)) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          id_next  = id_q + COMP_W'(1);
          cmd_next = toggle_cmd(id_q + COMP_W'(1), back_idx);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SPRITE_SEQ_IRQ_EN
  logic irq_q;

  // Completion wins over a same-cycle clear so a finished frame is never lost.
  always_ff @(posedge clk) begin
    if (reset)          irq_q <= 1'b0;
    else if (done)      irq_q <= 1'b1;
    else if (clear_req) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

  always_comb begin
    status             = '0;
    status[CNT_W-1:0]  = count;
    status[16]         = pending;
    status[17]         = back_idx;
    status[18]         = overflow;
    status[19]         = (state != IDLE);
`ifdef SPRITE_SEQ_IRQ_EN
    status[20]         = irq_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)                   readdata <= '0;
    else if (chipselect && read) readdata <= status;
  end

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Directed bench for sprite_cmd_sequencer: register access, vblank replay,
// toggle broadcast, overflow, deferred commits and reset abort.
module tb_sprite_cmd_sequencer;
  import sprite_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
`ifdef SPRITE_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  logic [31:0] rd;

  sprite_cmd_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vcount     (vcount),
`ifdef SPRITE_SEQ_IRQ_EN
    .irq        (irq),
`endif
    .cmd_out    (cmd_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stamp(input logic [31:0] w, input logic b);
    stamp     = w;
    stamp[13] = b;
  endfunction

  function automatic logic [31:0] tog(input int id, input logic b);
    logic [5:0] i6;
    i6  = id[5:0];
    tog = {i6, 5'd0, 4'hF, 3'd0, b, 13'd0};
  endfunction

  // driver tasks: inputs change #1 after the rising edge, outputs sampled there too
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = 2'd3;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic queue_toggles(input logic b);
    for (int id = 1; id <= 63; id++) exp_q.push_back(tog(id, b));
    exp_q.push_back(32'h0);
  endtask

  // Cross into vblank and compare cmd_out against the expected queue from T+1 on.
  task automatic run_frame(input string tag);
    int n;
    logic [31:0] e;
    n = exp_q.size();
    seen_q.delete();
    vcount = 10'd479;
    @(posedge clk); #1;
    vcount = 10'd480;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      seen_q.push_back(cmd_out);
      check(tag, cmd_out, e);
    end
    vcount = 10'd0;
  endtask

  task automatic end_frame();
`ifdef SPRITE_SEQ_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
`endif
    av_write(ADDR_CLEAR, 32'h0);
`ifdef SPRITE_SEQ_IRQ_EN
    check("irq_clr", {31'd0, irq}, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 2'd0; writedata = 32'h0; vcount = 10'd0;
    do_reset();

    check("rst_cmd", cmd_out, 32'h0);
    check("rst_rd", readdata, 32'h0);
`ifdef SPRITE_SEQ_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    av_read(rd);
    check("rst_status", rd, 32'h0002_0000);

    // two-word frame with the full toggle sweep
    av_write(ADDR_PUSH, 32'h2422_4005);
    av_write(ADDR_PUSH, 32'h2424_4064);
    av_write(ADDR_COMMIT, 32'hDEAD_BEEF);
    av_read(rd);
    check("f1_status_pre", rd, 32'h0003_0002);
    exp_q.push_back(32'h2422_6005);
    exp_q.push_back(32'h2424_6064);
    queue_toggles(1'b1);
    run_frame("f1_cmd");
    check("f1_id9", seen_q[10], 32'h241E_2000);
    end_frame();
    av_read(rd);
    check("f1_status_post", rd, 32'h0000_0000);

    // overflow: 256 fit, the 257th is dropped
    for (int i = 0; i < 256; i++) av_write(ADDR_PUSH, 32'h0100_0000 + i);
    av_read(rd);
    check("full_status", rd, 32'h0000_0100);
    av_write(ADDR_PUSH, 32'hFFFF_FFFF);
    av_read(rd);
    check("ovf_status", rd, 32'h0004_0100);
    av_write(ADDR_CLEAR, 32'h0);
    av_read(rd);
    check("ovf_clear", rd, 32'h0000_0100);
    av_write(2'd3, 32'h1234_5678);
    av_read(rd);
    check("addr3_noop", rd, 32'h0000_0100);
    do_reset();
    av_read(rd);
    check("flush_status", rd, 32'h0002_0000);

    // commit three, two more arrive late and wait for the next frame
    av_write(ADDR_PUSH, 32'h0400_2001);
    av_write(ADDR_PUSH, 32'h0800_0002);
    av_write(ADDR_PUSH, 32'h0C00_0003);
    av_write(ADDR_COMMIT, 32'h0);
    av_write(ADDR_PUSH, 32'h1000_2004);
    av_write(ADDR_COMMIT, 32'h0);
    av_write(ADDR_PUSH, 32'h1400_0005);
    av_read(rd);
    check("f2_status_pre", rd, 32'h0003_0005);
    exp_q.push_back(32'h0400_2001);
    exp_q.push_back(32'h0800_2002);
    exp_q.push_back(32'h0C00_2003);
    queue_toggles(1'b1);
    run_frame("f2_cmd");
    end_frame();
    av_read(rd);
    check("f2_status_post", rd, 32'h0000_0002);

    av_write(ADDR_COMMIT, 32'h0);
    exp_q.push_back(32'h1000_0004);
    exp_q.push_back(32'h1400_0005);
    queue_toggles(1'b0);
    run_frame("f3_cmd");
    end_frame();
    av_read(rd);
    check("f3_status_post", rd, 32'h0002_0000);

    // empty commit: sweep starts at T+1
    av_write(ADDR_COMMIT, 32'h0);
    queue_toggles(1'b1);
    run_frame("f4_cmd");
    end_frame();
    av_read(rd);
    check("f4_status_post", rd, 32'h0000_0000);

    // vblank without a commit leaves the bus idle
    for (int i = 0; i < 80; i++) exp_q.push_back(32'h0);
    run_frame("f5_idle");
    av_read(rd);
    check("f5_status", rd, 32'h0000_0000);

    // reset during drain
    av_write(ADDR_PUSH, 32'h1800_2007);
    av_write(ADDR_PUSH, 32'h1C00_0008);
    av_write(ADDR_PUSH, 32'h2000_0009);
    av_write(ADDR_COMMIT, 32'h0);
    vcount = 10'd479;
    @(posedge clk); #1;
    vcount = 10'd480;
    @(posedge clk); #1;
    check("abort_w0", cmd_out, 32'h1800_0007);
    @(posedge clk); #1;
    check("abort_w1", cmd_out, 32'h1C00_0008);
    av_read(rd);
    check("abort_busy", rd, 32'h0009_0001);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cmd", cmd_out, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    vcount = 10'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", cmd_out, 32'h0);
    end
    av_read(rd);
    check("abort_status", rd, 32'h0002_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
